// File: rtl/gpr_wr_arbiter.sv
// gpr_wr_arbiter: arbitrates pipeline and multi-cycle writebacks onto one GPR write port with req1 starvation guard
module gpr_wr_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  logic        req0_flag,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic [31:0] req0_nflag,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        WE,
  output logic [4:0]  AWr,
  output logic [31:0] Din,
  output logic [1:0]  FlagOp,
  output logic [31:0] NFlag,
  output logic        starved
);
  localparam logic [1:0] DIS = 2'd0, SET = 2'd1, SET_AND_WR = 2'd2;
  logic [2:0] starve_cnt;
  logic       we_q, w0;
  logic [1:0] fop_q;
  always_comb begin
    starved    = starve_cnt == 3'(STARVE_LIMIT);
    req1_ready = reset & req1_valid & (~req0_valid | starved);
    req0_ready = reset & req0_valid & ~req1_ready;
    w0         = req0_wr & |req0_addr;
    WE         = we_q & reset;
    FlagOp     = reset ? fop_q : DIS;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q       <= 1'b0;
      fop_q      <= DIS;
      AWr        <= 5'd0;
      Din        <= 32'd0;
      NFlag      <= 32'd0;
      starve_cnt <= 3'd0;
    end else begin
      we_q       <= req0_ready ? w0 : req1_ready & |req1_addr;
      fop_q      <= req0_ready & req0_flag ? (w0 ? SET_AND_WR : SET) : DIS;
      AWr        <= req0_ready ? req0_addr : req1_ready ? req1_addr : AWr;
      Din        <= req0_ready ? req0_data : req1_ready ? req1_data : Din;
      NFlag      <= req0_ready & req0_flag ? req0_nflag : NFlag;
      starve_cnt <= req1_valid & ~req1_ready ? (starved ? starve_cnt : starve_cnt + 3'd1) : 3'd0;
    end
  end
endmodule

// File: doc/gpr_wr_arbiter.md
GPR_WR_ARBITER -- requirements
Module: gpr_wr_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, default 4, number of consecutive cycles req1 may be denied before it is forced to win (range 1..7).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: req0_valid  input  1  pipeline writeback request.
REQ-005 SHALL have port: req0_wr  input  1  req0 carries a register write.
REQ-006 SHALL have port: req0_flag  input  1  req0 carries a Flag register update.
REQ-007 SHALL have port: req0_addr  input  5  req0 destination register.
REQ-008 SHALL have port: req0_data  input  32  req0 write data.
REQ-009 SHALL have port: req0_nflag  input  32  req0 new Flag value.
REQ-010 SHALL have port: req0_ready  output  1  req0 accepted this cycle.
REQ-011 SHALL have port: req1_valid  input  1  multi-cycle unit write request (write only, no flag).
REQ-012 SHALL have port: req1_addr  input  5  req1 destination register.
REQ-013 SHALL have port: req1_data  input  32  req1 write data.
REQ-014 SHALL have port: req1_ready  output  1  req1 accepted this cycle.
REQ-015 SHALL have port: WE  output  1  GPR write enable.
REQ-016 SHALL have port: AWr  output  5  GPR write address.
REQ-017 SHALL have port: Din  output  32  GPR write data.
REQ-018 SHALL have port: FlagOp  output  2  GPR flag op, encodings DIS/SET/SET_AND_WR from the shared macro header.
REQ-019 SHALL have port: NFlag  output  32  GPR new Flag value.
REQ-020 SHALL have port: starved  output  1  high while the starvation counter has reached STARVE_LIMIT.

Function
REQ-021 SHALL accept at most one request per cycle; req0_ready and req1_ready are combinational and never both high.
REQ-022 SHALL grant req0 when req0_valid=1, unless starve_cnt==STARVE_LIMIT and req1_valid=1, in which case req1 wins.
REQ-023 SHALL grant req1 when req1_valid=1 and req0_valid=0.
REQ-024 SHALL register the granted request onto WE/AWr/Din/FlagOp/NFlag for exactly the next cycle (1-cycle latency); GPR commits at the following posedge.
REQ-025 SHALL, in a cycle with no grant, drive WE=0, FlagOp=DIS next cycle; AWr/Din/NFlag hold previous values.
REQ-026 SHALL map req0 grant: wr&flag -> WE=1, FlagOp=SET_AND_WR; wr only -> WE=1, FlagOp=DIS; flag only -> WE=0, FlagOp=SET; neither -> accepted, WE=0, FlagOp=DIS.
REQ-027 SHALL map req1 grant -> WE=1, FlagOp=DIS, NFlag unchanged.
REQ-028 SHALL accept writes to register 0 normally but drive WE=0 for them; flag part of the same req0 still applies.
REQ-029 SHALL keep 3-bit starve_cnt: increment (saturating at STARVE_LIMIT) when req1_valid=1 and req1 not granted; clear on req1 grant or req1_valid=0.
REQ-030 SHALL assert starved combinationally when starve_cnt==STARVE_LIMIT.
REQ-031 SHALL not buffer requests: a denied requester holds valid/addr/data stable until its ready.

Reset
REQ-032 SHALL, on posedge clk with reset=0, set WE=0, FlagOp=DIS, AWr=0, Din=0, NFlag=0, starve_cnt=0; ready outputs 0 while reset=0.
REQ-033 SHALL discard any grant in a reset cycle; a request accepted the cycle before reset still issues its registered write only if reset is deasserted in the issue cycle, else WE=0.

Verification
REQ-034 SHALL pass: reset=0 two cycles, both valid -> WE=0, FlagOp=DIS, readies 0, starved=0.
REQ-035 SHALL pass: req0 wr addr=20 data=fedc1234 alone -> req0_ready=1, next cycle WE=1, AWr=20, Din=fedc1234, FlagOp=DIS.
REQ-036 SHALL pass: req0 wr+flag addr=21 data=98765432 nflag=12123434 -> next cycle WE=1, FlagOp=SET_AND_WR, NFlag=12123434.
REQ-037 SHALL pass: req0 and req1 valid continuously, STARVE_LIMIT=4 -> req0 granted 4 cycles, starved=1, req1 granted 5th cycle, counter cleared.
REQ-038 SHALL pass: req1 addr=0 data=23456789 -> req1_ready=1, next cycle WE=0.
REQ-039 SHALL pass: req0 flag-only nflag=1234cdef -> WE=0, FlagOp=SET, NFlag=1234cdef; following idle cycle FlagOp=DIS.
